// File: rtl/im_boot_loader.sv
// im_boot_loader
// Copies WORD_COUNT 16-bit words from board Flash into the instruction memory
// (Ram2) write port after reset, holding the CPU stalled until the image is in
// place. Once done, the write port is idle and Ram2 reverts to fetch-only use.
//
// Ports
//   Clk          system clock, rising edge
//   Rst          asynchronous active-low reset
//   BootStart    restart request, honoured only once the copy is done
//   Flash_addr   Flash word address (FLASH_BASE + idx, wraps at 23 bits)
//   Flash_data   Flash read data
//   Flash_CE     Flash chip enable, active-low
//   Flash_OE     Flash output enable, active-low
//   Flash_WE     Flash write enable, active-low, tied inactive
//   ImWrite      instruction memory write strobe (one cycle per word)
//   ImWriteAddr  Ram2 word address (= idx)
//   ImWriteData  Ram2 write data
//   CpuStall     1 = hold PC and fetch
//   BootDone     1 = image loaded
module im_boot_loader #(
  parameter int unsigned WORD_COUNT = 512,
  parameter logic [22:0] FLASH_BASE = 23'h0,
  parameter int unsigned FLASH_WAIT = 3
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        BootStart,
  output logic [22:0] Flash_addr,
  input  logic [15:0] Flash_data,
  output logic        Flash_CE,
  output logic        Flash_OE,
  output logic        Flash_WE,
  output logic        ImWrite,
  output logic [15:0] ImWriteAddr,
  output logic [15:0] ImWriteData,
  output logic        CpuStall,
  output logic        BootDone
);

  typedef enum logic [2:0] {
    S_START,
    S_ADDR,
    S_WAIT,
    S_LATCH,
    S_WRITE,
    S_RECOVER,
    S_DONE
  } state_t;

  localparam logic [15:0] LAST_IDX  = 16'(WORD_COUNT - 1);
  localparam bit          NO_WAIT   = (FLASH_WAIT == 0);
  // WAIT lasts cnt+1 cycles, so the counter is loaded one short.
  localparam logic [3:0]  WAIT_LOAD = NO_WAIT ? 4'd0 : 4'(FLASH_WAIT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] idx;
  logic [3:0]  wait_cnt;
  logic [15:0] data_q;
  logic        flash_en;

  // State register
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= S_START;
    end else begin
      state <= state_nxt;
    end
  end

  // Word index, wait counter and captured Flash word
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      idx      <= '0;
      wait_cnt <= '0;
      data_q   <= '0;
    end else begin
      case (state)
        S_ADDR:    wait_cnt <= WAIT_LOAD;
        S_WAIT:    if (wait_cnt != '0) wait_cnt <= wait_cnt - 4'd1;
        S_LATCH:   data_q <= Flash_data;
        // idx stays on the last word in DONE so ImWriteAddr never wraps.
        S_RECOVER: if (idx != LAST_IDX) idx <= idx + 16'd1;
        S_DONE:    if (BootStart) idx <= '0;
        default:   ;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_START:   state_nxt = S_ADDR;
      S_ADDR:    state_nxt = NO_WAIT ? S_LATCH : S_WAIT;
      S_WAIT:    if (wait_cnt == '0) state_nxt = S_LATCH;
      S_LATCH:   state_nxt = S_WRITE;
      S_WRITE:   state_nxt = S_RECOVER;
      S_RECOVER: state_nxt = (idx == LAST_IDX) ? S_DONE : S_ADDR;
      S_DONE:    if (BootStart) state_nxt = S_START;
      default:   state_nxt = S_START;
    endcase
  end

  // Outputs: decoded from state and registers only, never from inputs.
  always_comb begin
    flash_en    = 1'b0;
    ImWrite     = 1'b0;
    CpuStall    = 1'b1;
    BootDone    = 1'b0;
    case (state)
      S_ADDR, S_WAIT, S_LATCH: flash_en = 1'b1;
      S_WRITE:                 ImWrite  = 1'b1;
      S_DONE: begin
        CpuStall = 1'b0;
        BootDone = 1'b1;
      end
      default: ;
    endcase
    Flash_CE    = ~flash_en;
    Flash_OE    = ~flash_en;
    Flash_WE    = 1'b1;
    Flash_addr  = FLASH_BASE + {7'd0, idx};
    ImWriteAddr = idx;
    ImWriteData = data_q;
  end

endmodule

// File: tb/tb_im_boot_loader.sv
// Testbench for im_boot_loader: three instances (default-wait 4-word image,
// zero-wait 3-word image, 4-word image near the top of Flash) checked every
// cycle against a cycle-formula reference model, plus a table of the key
// cycles of the 4-word copy and hand-written reset/restart sequences.
module tb_im_boot_loader;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Rst;
  logic [2:0]  bs;

  logic [22:0] fa_a, fa_b, fa_c;
  logic [15:0] fd_a, fd_b, fd_c;
  logic        ce_a, ce_b, ce_c, oe_a, oe_b, oe_c, we_a, we_b, we_c;
  logic        wr_a, wr_b, wr_c, st_a, st_b, st_c, dn_a, dn_b, dn_c;
  logic [15:0] wa_a, wa_b, wa_c, wd_a, wd_b, wd_c;

  logic [15:0] mem [256];

  // Flash: data only valid while selected and output-enabled
  assign fd_a = (!ce_a && !oe_a) ? mem[fa_a[7:0]] : 16'hDEAD;
  assign fd_b = (!ce_b && !oe_b) ? mem[fa_b[7:0]] : 16'hDEAD;
  assign fd_c = (!ce_c && !oe_c) ? mem[fa_c[7:0]] : 16'hDEAD;

  im_boot_loader #(.WORD_COUNT(4), .FLASH_BASE(23'h0), .FLASH_WAIT(3)) u_a (
    .Clk(Clk), .Rst(Rst), .BootStart(bs[0]), .Flash_addr(fa_a), .Flash_data(fd_a),
    .Flash_CE(ce_a), .Flash_OE(oe_a), .Flash_WE(we_a), .ImWrite(wr_a),
    .ImWriteAddr(wa_a), .ImWriteData(wd_a), .CpuStall(st_a), .BootDone(dn_a));

  im_boot_loader #(.WORD_COUNT(3), .FLASH_BASE(23'h0), .FLASH_WAIT(0)) u_b (
    .Clk(Clk), .Rst(Rst), .BootStart(bs[1]), .Flash_addr(fa_b), .Flash_data(fd_b),
    .Flash_CE(ce_b), .Flash_OE(oe_b), .Flash_WE(we_b), .ImWrite(wr_b),
    .ImWriteAddr(wa_b), .ImWriteData(wd_b), .CpuStall(st_b), .BootDone(dn_b));

  im_boot_loader #(.WORD_COUNT(4), .FLASH_BASE(23'h7FFFFE), .FLASH_WAIT(3)) u_c (
    .Clk(Clk), .Rst(Rst), .BootStart(bs[2]), .Flash_addr(fa_c), .Flash_data(fd_c),
    .Flash_CE(ce_c), .Flash_OE(oe_c), .Flash_WE(we_c), .ImWrite(wr_c),
    .ImWriteAddr(wa_c), .ImWriteData(wd_c), .CpuStall(st_c), .BootDone(dn_c));

  // Absolute cycle number since reset release; org[i] is cycle 0 of the
  // current copy of instance i.
  int cyc;
  int org [3];
  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always @(posedge Clk or negedge Rst)
    if (!Rst) cyc <= 0;
    else      cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        wr;
    logic [15:0] waddr;
    logic [15:0] wdata;
    bit          chkd;
    logic        ce;
    logic        stall;
    logic        done;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(input int c, input logic wr, input logic [15:0] wa,
                              input logic [15:0] wd, input bit cd, input logic ce,
                              input logic st, input logic dn);
    vec_t v;
    v.cyc = c; v.wr = wr; v.waddr = wa; v.wdata = wd; v.chkd = cd;
    v.ce = ce; v.stall = st; v.done = dn;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: expected outputs of a loader at cycle rel of its copy.
  task automatic check_inst(input string nm, input int rel, input int wc, input int fw,
                            input logic [22:0] base, input logic [44:0] act,
                            input logic [15:0] act_d);
    int p, dn, k, ph;
    logic wr, ce, st, don;
    bit cd;
    logic [22:0] fa;
    p  = 4 + fw;
    dn = 1 + wc * p;
    wr = 1'b0; ce = 1'b1; st = 1'b1; don = 1'b0; cd = 1'b0; k = 0;
    if (rel >= dn) begin
      k = wc - 1; st = 1'b0; don = 1'b1;
    end else if (rel > 0) begin
      k  = (rel - 1) / p;
      ph = (rel - 1) % p;
      wr = (ph == fw + 2);
      ce = !(ph < fw + 2);
      cd = (ph >= fw + 2);
    end
    fa = base + 23'(k);
    cmp(nm, 64'(act), 64'({wr, ce, ce, 1'b1, st, don, 16'(k), fa}));
    if (cd) cmp({nm, "_data"}, 64'(act_d), 64'(mem[fa[7:0]]));
  endtask

  function automatic logic done_of(input int i);
    case (i)
      0:       return dn_a;
      1:       return dn_b;
      default: return dn_c;
    endcase
  endfunction

  task automatic chk_reset();
    cmp("rst_a", 64'({wr_a, ce_a, oe_a, we_a, st_a, dn_a, wa_a, fa_a, wd_a}),
        64'({1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0, 23'd0, 16'd0}));
    cmp("rst_b", 64'({wr_b, ce_b, st_b, dn_b, wa_b, wd_b}),
        64'({1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0}));
    cmp("rst_c_faddr", 64'(fa_c), 64'(23'h7FFFFE));
  endtask

  task automatic assert_reset();
    Rst = 1'b0;
    org[0] = 0; org[1] = 0; org[2] = 0;
    #1 chk_reset();
    repeat (2) @(posedge Clk);
    #2 Rst = 1'b1;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 13; i++) begin
      int g;
      g = 0;
      do begin
        @(negedge Clk);
        g++;
      end while ((cyc - org[0]) != tbl[i].cyc && g < 64);
      if ((cyc - org[0]) != tbl[i].cyc) begin
        n_cmp++; n_err++;
        $display("FAIL %s_sync: cycle got %0d expected %0d", tag, cyc - org[0], tbl[i].cyc);
      end else begin
        cmp($sformatf("%s_c%0d", tag, tbl[i].cyc),
            64'({wr_a, ce_a, oe_a, we_a, st_a, dn_a, wa_a, fa_a}),
            64'({tbl[i].wr, tbl[i].ce, tbl[i].ce, 1'b1, tbl[i].stall, tbl[i].done,
                 tbl[i].waddr, 7'd0, tbl[i].waddr}));
        if (tbl[i].chkd)
          cmp($sformatf("%s_c%0d_data", tag, tbl[i].cyc), 64'(wd_a), 64'(tbl[i].wdata));
      end
    end
  endtask

  task automatic restart(input int i);
    int g;
    g = 0;
    while (!done_of(i) && g < 500) begin
      @(posedge Clk);
      #2 g++;
    end
    if (!done_of(i)) begin
      n_cmp++; n_err++;
      $display("FAIL restart%0d_timeout: BootDone got 0 expected 1", i);
    end else begin
      bs[i] = 1'b1;
      @(posedge Clk);
      #1 org[i] = cyc;
      bs[i] = 1'b0;
    end
  endtask

  task automatic busy_pulse(input int i);
    repeat ($urandom_range(1, 10)) @(posedge Clk);
    #2 bs[i] = 1'b1;
    @(posedge Clk);
    #2 bs[i] = 1'b0;
  endtask

  task automatic wait_all_done();
    int g;
    g = 0;
    while (!(dn_a && dn_b && dn_c) && g < 500) begin
      @(posedge Clk);
      #2 g++;
    end
    n_cmp++;
    if (!(dn_a && dn_b && dn_c)) begin
      n_err++;
      $display("FAIL all_done_timeout: done got %b%b%b expected 111", dn_a, dn_b, dn_c);
    end
  endtask

  initial begin
    Rst = 1'b1;
    bs  = '0;
    org[0] = 0; org[1] = 0; org[2] = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i) ^ 16'hA5A5;

    tbl[0]  = mk(0,  1'b0, 16'd0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[1]  = mk(1,  1'b0, 16'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[2]  = mk(5,  1'b0, 16'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[3]  = mk(6,  1'b1, 16'd0, 16'hA5A5, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[4]  = mk(7,  1'b0, 16'd0, 16'hA5A5, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[5]  = mk(8,  1'b0, 16'd1, 16'hA5A5, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[6]  = mk(13, 1'b1, 16'd1, 16'hA5A4, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[7]  = mk(14, 1'b0, 16'd1, 16'hA5A4, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[8]  = mk(20, 1'b1, 16'd2, 16'hA5A7, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[9]  = mk(27, 1'b1, 16'd3, 16'hA5A6, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[10] = mk(28, 1'b0, 16'd3, 16'hA5A6, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[11] = mk(29, 1'b0, 16'd3, 16'hA5A6, 1'b1, 1'b1, 1'b0, 1'b1);
    tbl[12] = mk(30, 1'b0, 16'd3, 16'hA5A6, 1'b1, 1'b1, 1'b0, 1'b1);

    // Per-cycle model check of all three instances
    fork
      forever begin
        @(negedge Clk);
        if (Rst && chk_en) begin
          check_inst("a", cyc - org[0], 4, 3, 23'h0,
                     {wr_a, ce_a, oe_a, we_a, st_a, dn_a, wa_a, fa_a}, wd_a);
          check_inst("b", cyc - org[1], 3, 0, 23'h0,
                     {wr_b, ce_b, oe_b, we_b, st_b, dn_b, wa_b, fa_b}, wd_b);
          check_inst("c", cyc - org[2], 4, 3, 23'h7FFFFE,
                     {wr_c, ce_c, oe_c, we_c, st_c, dn_c, wa_c, fa_c}, wd_c);
        end
      end
    join_none

    #3 Rst = 1'b0;
    #1 chk_reset();
    repeat (2) @(posedge Clk);
    #2 Rst = 1'b1;
    chk_en = 1'b1;

    // First copy, with a BootStart pulse while busy that must be ignored
    fork
      run_table("run1");
      begin
        while (cyc != 10) begin
          @(posedge Clk);
          #2;
        end
        bs[0] = 1'b1;
        @(posedge Clk);
        #2 bs[0] = 1'b0;
      end
    join

    // Reset in cycle 15 of a fresh copy, then the copy must restart cleanly
    @(posedge Clk);
    #1 assert_reset();
    for (int g = 0; g < 40 && cyc != 15; g++) begin
      @(posedge Clk);
      #1;
    end
    assert_reset();
    run_table("run2");

    // Single BootStart pulse in DONE repeats the copy with identical timing
    restart(0);
    run_table("run3");

    // Randomised images and restart times
    for (int r = 0; r < 6; r++) begin
      wait_all_done();
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      fork
        begin repeat ($urandom_range(0, 5)) @(posedge Clk); #2 restart(0); busy_pulse(0); end
        begin repeat ($urandom_range(0, 5)) @(posedge Clk); #2 restart(1); busy_pulse(1); end
        begin repeat ($urandom_range(0, 5)) @(posedge Clk); #2 restart(2); busy_pulse(2); end
      join
    end
    wait_all_done();
    repeat (3) @(posedge Clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/im_boot_loader.md
# im_boot_loader

Boot loader that copies the program image from the board Flash into Ram2 (instruction memory) after reset, driving the instruction memory's write port (ImWrite / ImWriteAddr / ImWriteData). It sits directly upstream of the instruction memory and holds the CPU stalled until the copy completes. After completion it releases the write port, and the instruction memory returns to read-only fetch.

## Interface
Parameters:
- WORD_COUNT, 512: number of 16-bit words copied; legal 1..65535.
- FLASH_BASE, 23'h0: Flash word address of image word 0.
- FLASH_WAIT, 3: extra cycles Flash_addr/CE/OE are held before data is sampled; legal 0..15.

Ports:
- Clk  in  1  system clock; all state changes on rising edge.
- Rst  in  1  reset, asynchronous, active-low.
- BootStart  in  1  restart request; sampled only in DONE.
- Flash_addr  out  23  Flash word address.
- Flash_data  in  16  Flash read data.
- Flash_CE  out  1  Flash chip enable, active-low.
- Flash_OE  out  1  Flash output enable, active-low.
- Flash_WE  out  1  Flash write enable, active-low; constant 1.
- ImWrite  out  1  instruction memory write strobe; Ram2 WE pulses low in the low phase of Clk during this cycle.
- ImWriteAddr  out  16  Ram2 word address.
- ImWriteData  out  16  Ram2 write data.
- CpuStall  out  1  1 = hold PC and fetch.
- BootDone  out  1  1 = image loaded.

## Operation
- All outputs are registered or decoded from state only; no combinational path from any input to any output.
- Word index `idx` is a 16-bit counter starting at 0.
- Flash_addr = FLASH_BASE + idx, computed at 23 bits and wrapping modulo 2^23.
- ImWriteAddr = idx.
- FSM states and transitions:
  - START: all strobes inactive -> ADDR.
  - ADDR: Flash_CE = Flash_OE = 0 -> WAIT, or -> LATCH if FLASH_WAIT = 0.
  - WAIT: CE/OE held low for FLASH_WAIT cycles (down-counter) -> LATCH.
  - LATCH: CE/OE held low; ImWriteData <= Flash_data at the rising edge leaving LATCH -> WRITE.
  - WRITE: ImWrite = 1 for exactly one cycle; address and data held -> RECOVER.
  - RECOVER: ImWrite = 0; address and data held, so the Ram2 WE rising edge has no address/data race. Leaving RECOVER:
    - if idx = WORD_COUNT-1 -> DONE, with idx unchanged;
    - otherwise idx <= idx+1 -> ADDR.
  - DONE: CE/OE = 1, ImWrite = 0. BootStart = 1 -> START with idx <= 0.
- Flash_CE/Flash_OE are 0 only in ADDR, WAIT and LATCH; 1 in every other state.
- Flash_WE is always 1.
- CpuStall = 1 in every state except DONE.
- BootDone = 1 only in DONE.
- BootStart is ignored in every state other than DONE.

## Timing
- Reset (Rst = 0) forces, asynchronously:
  - state = START, idx = 0, FLASH_WAIT counter = 0;
  - ImWrite = 0, ImWriteAddr = 0, ImWriteData = 0;
  - Flash_addr = FLASH_BASE, Flash_CE = Flash_OE = Flash_WE = 1;
  - CpuStall = 1, BootDone = 0.
- Cycle numbering: cycle 0 is the cycle ending at the first rising edge after Rst goes to 1 (state START).
- Per word: 4 + FLASH_WAIT cycles (ADDR, WAIT×FLASH_WAIT, LATCH, WRITE, RECOVER).
- Word k (0-based): ImWrite is high in cycle 1 + k·(4+FLASH_WAIT) + FLASH_WAIT + 2.
- BootDone/DONE begins at cycle 1 + WORD_COUNT·(4+FLASH_WAIT).
- Defaults (FLASH_WAIT = 3, WORD_COUNT = 512): 7 cycles/word; DONE at cycle 3585.
- Reset mid-copy: all progress is discarded and the copy restarts from word 0 after release. A partially written word is simply rewritten.
- BootStart held high in DONE: causes one restart; after returning to DONE it causes another, so callers pulse it.
- idx never exceeds WORD_COUNT-1; there is no wrap of ImWriteAddr.

## Test plan
- WORD_COUNT = 4, defaults, Flash model returns data = addr ^ 16'hA5A5 -> ImWrite pulses only in cycles 6, 13, 20, 27 with (ImWriteAddr, ImWriteData) = (0, A5A5), (1, A5A4), (2, A5A7), (3, A5A6); BootDone and CpuStall=0 from cycle 29.
- FLASH_WAIT = 0, WORD_COUNT = 3 -> ImWrite in cycles 3, 7, 11; DONE at cycle 13; CE/OE low exactly 2 cycles per word.
- FLASH_BASE = 23'h7FFFFE, WORD_COUNT = 4 -> Flash_addr sequence 7FFFFE, 7FFFFF, 000000, 000001, while ImWriteAddr = 0..3.
- Assert Rst low in cycle 15 of the WORD_COUNT = 4 run -> outputs return to reset values immediately; after release, ImWrite pulses are again at cycles 6, 13, 20, 27 with addr 0..3.
- BootStart pulsed in cycle 10 (busy) -> no effect. BootStart pulsed one cycle while in DONE -> CpuStall = 1 next cycle and a full 4-word copy repeats with identical timing.
- Every ImWrite cycle: ImWriteAddr/ImWriteData unchanged from the LATCH edge through the end of RECOVER; Flash_WE is never 0.
